ordering_io_ctrl: RTL and testbench
===================================

Name: ordering_io_ctrl

Overview:
- Host-side loader/unloader for the per-replica city-ordering RAMs of the replica-exchange salesman annealer.
- Write path: accepts 64-bit beats of eight 8-bit city indices and serialises them into one-city-per-cycle RAM writes. It walks replicas 0..REPLICA_NUM-1.
- Read path: the reverse, gathering eight cities per beat.
- Sits between the top-level ordering_* host interface and the replica ordering storage.

Parameters:
- REPLICA_NUM, 32, number of replicas; replica pointer wraps at this value.
- CITY_NUM, 31, cities per ordering (index 0 = fixed start city); beats per replica BPR = ceil(CITY_NUM/8) = 4.
- CITY_NUM_LOG, 5, width of the RAM city address.
- REPLICA_LOG, 5, width of the RAM replica select.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ptr_clear  in  1  one-cycle pulse: return replica/city pointers to 0.
- ordering_write  in  1  host write request; level, held until ready seen.
- ordering_wdata  in  64  [7:0][7:0] beat; byte 7 = lowest city index of beat.
- ordering_read  in  1  host read request; level.
- ordering_ready  out  1  one-cycle pulse: write beat consumed, or read beat presented.
- ordering_out_valid  out  1  one-cycle pulse coincident with ready on reads.
- ordering_out_data  out  64  [7:0][7:0] read beat, same byte order as wdata.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe; data returns next cycle.
- ram_replica  out  REPLICA_LOG  replica select.
- ram_addr  out  CITY_NUM_LOG  city position.
- ram_wdata  out  8  city index to write.
- ram_rdata  in  8  city index read; valid one cycle after ram_re.
- io_busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset and ptr_clear (also mid-beat): FSM IDLE; rep_ptr=0; pos_ptr=0; beat latch=0; all outputs 0.
- FSM states:
  - IDLE -> WR_SER when ordering_write=1. Capture wdata into the latch and pulse ordering_ready in the same cycle the state is entered.
  - IDLE -> RD_REQ when ordering_read=1 and ordering_write=0. Write has priority when both are high.
- WR_SER:
  - 8 cycles with k=0..7. Cycle k drives ram_addr=pos_ptr+k and ram_wdata=latch[7-k].
  - ram_we=1 only if pos_ptr+k < CITY_NUM. Padding positions issue no write.
  - After k=7, pos_ptr+=8. Return to IDLE; a new beat can be captured on the following cycle.
- RD_REQ / RD_COL:
  - Issue ram_re for k=0..7 on consecutive cycles, with addresses as above.
  - Capture ram_rdata into byte 7-k one cycle later. Padding positions load 0 (ram_re not asserted).
  - Cycle after the last capture: drive ordering_out_data, pulse ordering_ready and ordering_out_valid. Then return to IDLE.
  - Read beat latency from request: 10 cycles.
- ordering_out_data holds its value until the next read beat.
- Pointer advance: when pos_ptr reaches BPR*8 after a beat, pos_ptr=0 and rep_ptr+=1. rep_ptr wraps REPLICA_NUM-1 -> 0.
- Pointers persist across request deassertion. A new replica's load continues where the last one ended.
- Dropping ordering_write/ordering_read mid-beat does not abort the beat in flight; the FSM completes it.
- ram_replica=rep_ptr whenever ram_we or ram_re is high.

Optional Feature:
- ORDERING_CHECK_EN defined:
  - Adds output ordering_err (1). It is set sticky when a written non-padding byte is >= CITY_NUM, or when byte 7 of a replica's first beat is non-zero (start city must be 0).
  - The offending write still occurs.
  - ordering_err is cleared by reset or ptr_clear.
- Undefined: no ordering_err port; no checking logic.

Test Plan:
- Reset, then write 4 beats of 0..30 (last beat 24..30 plus one pad byte 0) -> 31 ram_we pulses, addrs 0..30, replica 0, data=addr, 4 ready pulses, no write at addr 31; rep_ptr=1 afterwards.
- Load all 32 replicas, then ptr_clear and read 4 beats -> each out_data matches written bytes, pad byte 0, ready/out_valid 10 cycles after each request.
- Write replica 31 then one more beat -> beat lands on replica 0 (wrap).
- ordering_write and ordering_read asserted together in IDLE -> write path taken, no ram_re.
- Reset asserted on cycle 3 of WR_SER -> no further ram_we, io_busy=0 next cycle, next write lands at replica 0 addr 0.
- ORDERING_CHECK_EN: write byte 0x1F (31) at a non-pad position -> ordering_err=1 and stays 1 until ptr_clear.

Source files
------------

// File: rtl/ordering_io_ctrl.sv
// Host-side loader/unloader for the per-replica city-ordering RAMs: serialises 64-bit beats
// into one-city-per-cycle RAM accesses and back. Optional input checking under ORDERING_CHECK_EN.
module ordering_io_ctrl #(
  parameter int unsigned REPLICA_NUM  = 32,
  parameter int unsigned CITY_NUM     = 31,
  parameter int unsigned CITY_NUM_LOG = 5,
  parameter int unsigned REPLICA_LOG  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ptr_clear,
  input  logic                    ordering_write,
  input  logic [7:0][7:0]         ordering_wdata,
  input  logic                    ordering_read,
  output logic                    ordering_ready,
  output logic                    ordering_out_valid,
  output logic [7:0][7:0]         ordering_out_data,
  output logic                    ram_we,
  output logic                    ram_re,
  output logic [REPLICA_LOG-1:0]  ram_replica,
  output logic [CITY_NUM_LOG-1:0] ram_addr,
  output logic [7:0]              ram_wdata,
  input  logic [7:0]              ram_rdata,
  output logic                    io_busy
`ifdef ORDERING_CHECK_EN
  ,
  output logic                    ordering_err
`endif
);

  localparam int unsigned K_W       = 3;
  localparam int unsigned BPR       = (CITY_NUM + 7) / 8;
  localparam int unsigned POS_W     = CITY_NUM_LOG + 1;
  localparam int unsigned BEAT_SPAN = BPR * 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_SER  = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_COL  = 3'd3,
    S_RD_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [K_W-1:0]          r_k;
  logic [K_W-1:0]          w_k_nxt;
  logic [CITY_NUM_LOG-1:0] r_pos;
  logic [CITY_NUM_LOG-1:0] w_pos_nxt;
  logic [REPLICA_LOG-1:0]  r_rep;
  logic [REPLICA_LOG-1:0]  w_rep_nxt;
  logic [7:0][7:0]         r_latch;
  logic [7:0][7:0]         w_latch_nxt;
  logic [7:0][7:0]         r_rbeat;
  logic [7:0][7:0]         w_rbeat_nxt;
  logic [7:0][7:0]         r_out_data;
  logic [POS_W-1:0]        w_pos_sum;
  logic [POS_W-1:0]        w_addr_full;
  logic                    w_serial;
  logic                    w_beat_end;
  logic                    w_capture;
  logic                    w_in_range;
  logic                    w_issue_wr;
  logic                    w_issue_rd;
  logic [7:0]              w_cap_byte;

  logic                    r_ready;
  logic                    r_out_valid;
  logic                    r_ram_we;
  logic                    r_ram_re;
  logic [REPLICA_LOG-1:0]  r_ram_replica;
  logic [CITY_NUM_LOG-1:0] r_ram_addr;
  logic [7:0]              r_ram_wdata;
  logic                    r_busy;
  logic                    r_re_d;
  logic                    r_cap_en;
  logic [K_W-1:0]          r_cap_k;

  logic                    w_ready_nxt;
  logic                    w_valid_nxt;
  logic                    w_ram_we_nxt;
  logic                    w_ram_re_nxt;
  logic [REPLICA_LOG-1:0]  w_ram_replica_nxt;
  logic [CITY_NUM_LOG-1:0] w_ram_addr_nxt;
  logic [7:0]              w_ram_wdata_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset || ptr_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; write wins when both requests are high in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ordering_write) begin
          w_state_nxt = S_WR_SER;
        end else if (ordering_read) begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_WR_SER:  if (r_k == K_W'(7)) w_state_nxt = S_IDLE;
      S_RD_REQ:  if (r_k == K_W'(7)) w_state_nxt = S_RD_COL;
      S_RD_COL:  w_state_nxt = S_RD_DONE;
      S_RD_DONE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered output and the pointer/latch datapath
  always_comb begin
    w_serial    = (r_state == S_WR_SER) || (r_state == S_RD_REQ);
    w_beat_end  = w_serial && (r_k == K_W'(7));
    w_capture   = (r_state == S_IDLE) && (w_state_nxt == S_WR_SER);
    w_k_nxt     = '0;
    w_pos_nxt   = r_pos;
    w_rep_nxt   = r_rep;
    w_latch_nxt = r_latch;
    w_pos_sum   = POS_W'(r_pos) + POS_W'(8);
    if (w_serial && !w_beat_end) begin
      w_k_nxt = r_k + K_W'(1);
    end
    if (w_beat_end) begin
      if (w_pos_sum == POS_W'(BEAT_SPAN)) begin
        w_pos_nxt = '0;
        w_rep_nxt = (r_rep == REPLICA_LOG'(REPLICA_NUM - 1)) ? '0 : r_rep + REPLICA_LOG'(1);
      end else begin
        w_pos_nxt = CITY_NUM_LOG'(w_pos_sum);
      end
    end
    if (w_capture) begin
      w_latch_nxt = ordering_wdata;
    end

    // Positions past the last city are padding: address still walks, strobe stays low
    w_addr_full       = POS_W'(w_pos_nxt) + POS_W'(w_k_nxt);
    w_in_range        = w_addr_full < POS_W'(CITY_NUM);
    w_issue_wr        = (w_state_nxt == S_WR_SER);
    w_issue_rd        = (w_state_nxt == S_RD_REQ);
    w_ram_we_nxt      = w_issue_wr && w_in_range;
    w_ram_re_nxt      = w_issue_rd && w_in_range;
    w_ram_addr_nxt    = (w_issue_wr || w_issue_rd) ? CITY_NUM_LOG'(w_addr_full) : '0;
    w_ram_replica_nxt = (w_ram_we_nxt || w_ram_re_nxt) ? w_rep_nxt : '0;
    w_ram_wdata_nxt   = w_issue_wr ? w_latch_nxt[K_W'(7) - w_k_nxt] : '0;
    w_ready_nxt       = w_capture || (w_state_nxt == S_RD_DONE);
    w_valid_nxt       = (w_state_nxt == S_RD_DONE);

    w_cap_byte  = r_re_d ? ram_rdata : '0;
    w_rbeat_nxt = r_rbeat;
    if (r_cap_en) begin
      w_rbeat_nxt[K_W'(7) - r_cap_k] = w_cap_byte;
    end
  end

  // Datapath and output registers; ptr_clear behaves like reset for this block
  always_ff @(posedge clk) begin
    if (reset || ptr_clear) begin
      r_k           <= '0;
      r_pos         <= '0;
      r_rep         <= '0;
      r_latch       <= '0;
      r_rbeat       <= '0;
      r_out_data    <= '0;
      r_ready       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_re      <= 1'b0;
      r_ram_replica <= '0;
      r_ram_addr    <= '0;
      r_ram_wdata   <= '0;
      r_busy        <= 1'b0;
      r_re_d        <= 1'b0;
      r_cap_en      <= 1'b0;
      r_cap_k       <= '0;
    end else begin
      r_k           <= w_k_nxt;
      r_pos         <= w_pos_nxt;
      r_rep         <= w_rep_nxt;
      r_latch       <= w_latch_nxt;
      r_rbeat       <= w_rbeat_nxt;
      r_ready       <= w_ready_nxt;
      r_out_valid   <= w_valid_nxt;
      r_ram_we      <= w_ram_we_nxt;
      r_ram_re      <= w_ram_re_nxt;
      r_ram_replica <= w_ram_replica_nxt;
      r_ram_addr    <= w_ram_addr_nxt;
      r_ram_wdata   <= w_ram_wdata_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_re_d        <= r_ram_re;
      r_cap_en      <= (r_state == S_RD_REQ);
      r_cap_k       <= r_k;
      if (r_state == S_RD_COL) begin
        r_out_data <= w_rbeat_nxt;
      end
    end
  end

  assign ordering_ready     = r_ready;
  assign ordering_out_valid = r_out_valid;
  assign ordering_out_data  = r_out_data;
  assign ram_we             = r_ram_we;
  assign ram_re             = r_ram_re;
  assign ram_replica        = r_ram_replica;
  assign ram_addr           = r_ram_addr;
  assign ram_wdata          = r_ram_wdata;
  assign io_busy            = r_busy;

`ifdef ORDERING_CHECK_EN
  logic r_err;
  logic w_err_set;

  // Flag out-of-range cities and a non-zero start city on a replica's first beat
  always_comb begin
    w_err_set = 1'b0;
    if (w_capture) begin
      if ((r_pos == '0) && (ordering_wdata[7] != 8'h00)) begin
        w_err_set = 1'b1;
      end
      for (int j = 0; j < 8; j++) begin
        if (((POS_W'(r_pos) + POS_W'(j)) < POS_W'(CITY_NUM)) &&
            (32'(ordering_wdata[7-j]) >= CITY_NUM)) begin
          w_err_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ptr_clear) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign ordering_err = r_err;
`endif

endmodule

// File: tb/tb_ordering_io_ctrl.sv
// Directed bench for ordering_io_ctrl with a behavioural ordering RAM model.
module tb_ordering_io_ctrl;

  logic            clk = 1'b0;
  logic            reset;
  logic            ptr_clear;
  logic            ordering_write;
  logic [7:0][7:0] ordering_wdata;
  logic            ordering_read;
  logic            ordering_ready;
  logic            ordering_out_valid;
  logic [7:0][7:0] ordering_out_data;
  logic            ram_we;
  logic            ram_re;
  logic [4:0]      ram_replica;
  logic [4:0]      ram_addr;
  logic [7:0]      ram_wdata;
  logic [7:0]      ram_rdata;
  logic            io_busy;
`ifdef ORDERING_CHECK_EN
  logic            ordering_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int rdy_cnt  = 0;
  logic [7:0] mem [32][32];
  logic       mem_init;

  always #5 clk = ~clk;

  ordering_io_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .ptr_clear          (ptr_clear),
    .ordering_write     (ordering_write),
    .ordering_wdata     (ordering_wdata),
    .ordering_read      (ordering_read),
    .ordering_ready     (ordering_ready),
    .ordering_out_valid (ordering_out_valid),
    .ordering_out_data  (ordering_out_data),
    .ram_we             (ram_we),
    .ram_re             (ram_re),
    .ram_replica        (ram_replica),
    .ram_addr           (ram_addr),
    .ram_wdata          (ram_wdata),
    .ram_rdata          (ram_rdata),
    .io_busy            (io_busy)
`ifdef ORDERING_CHECK_EN
    ,
    .ordering_err       (ordering_err)
`endif
  );

  // RAM model with one-cycle read latency, plus strobe counters
  always @(posedge clk) begin
    if (mem_init) begin
      for (int r = 0; r < 32; r++)
        for (int p = 0; p < 32; p++)
          mem[r][p] <= 8'hEE;
    end else if (ram_we === 1'b1) begin
      mem[ram_replica][ram_addr] <= ram_wdata;
    end
    ram_rdata <= (ram_re === 1'b1) ? mem[ram_replica][ram_addr] : 8'hA5;
    if (ram_we === 1'b1) we_cnt <= we_cnt + 1;
    if (ram_re === 1'b1) re_cnt <= re_cnt + 1;
    if (ordering_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
  end

  function automatic logic [7:0] val(input int r, input int p);
    if (p >= 31) return 8'h00;
    if (r == 0 || p == 0) return 8'(p);
    return 8'(((p + r) % 30) + 1);
  endfunction

  function automatic logic [63:0] beat(input int r, input int b);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) w[8*(7-j) +: 8] = val(r, 8*b + j);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (io_busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(io_busy), 64'(0));
  endtask

  task automatic wr_beat(input logic [63:0] d);
    int n;
    ordering_wdata = d;
    ordering_write = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (ordering_ready !== 1'b1 && n < 20);
    ordering_write = 1'b0;
    chk("wr_ready_latency", 64'(n), 64'(1));
    wait_idle("wr_idle");
  endtask

  task automatic rd_beat(input logic [63:0] exp);
    int n;
    ordering_read = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (ordering_ready !== 1'b1 && n < 30);
    ordering_read = 1'b0;
    chk("rd_latency", 64'(n), 64'(10));
    chk("rd_out_valid", 64'(ordering_out_valid), 64'(1));
    chk("rd_out_data", ordering_out_data, exp);
    step();
    chk("rd_ready_pulse", 64'(ordering_ready), 64'(0));
    chk("rd_data_hold", ordering_out_data, exp);
    wait_idle("rd_idle");
  endtask

  function automatic int mem_bad(input int r, input int p0, input int p1, input logic [63:0] bt,
                                 input bit use_bt);
    int bad;
    bad = 0;
    for (int p = p0; p <= p1; p++) begin
      if (use_bt) begin
        if (mem[r][p] !== bt[8*(7-(p-p0)) +: 8]) bad++;
      end else if (mem[r][p] !== val(r, p)) begin
        bad++;
      end
    end
    return bad;
  endfunction

  localparam logic [63:0] WRAP_BEAT = 64'h00_1E_1D_1C_1B_1A_19_18;
  localparam logic [63:0] BOTH_BEAT = 64'h00_02_04_06_08_0A_0C_0E;
  localparam logic [63:0] RST_BEAT  = 64'h11_12_13_14_15_16_17_18;
  localparam logic [63:0] Y_BEAT    = 64'h00_03_05_07_09_0B_0D_0F;

  initial begin
    int snap_we;
    int snap_re;
    int snap_rdy;
    int bad;
    int n;

    reset          = 1'b1;
    ptr_clear      = 1'b0;
    ordering_write = 1'b0;
    ordering_read  = 1'b0;
    ordering_wdata = '0;
    mem_init       = 1'b1;
    step();
    mem_init = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_ready", 64'(ordering_ready), 64'(0));
    chk("rst_out_valid", 64'(ordering_out_valid), 64'(0));
    chk("rst_out_data", ordering_out_data, 64'(0));
    chk("rst_ram_we", 64'(ram_we), 64'(0));
    chk("rst_ram_re", 64'(ram_re), 64'(0));
    chk("rst_busy", 64'(io_busy), 64'(0));
    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
    chk("rst_ram_replica", 64'(ram_replica), 64'(0));
`ifdef ORDERING_CHECK_EN
    chk("rst_err", 64'(ordering_err), 64'(0));
`endif

    // Replica 0: cities 0..30 plus one pad byte
    snap_we  = we_cnt;
    snap_rdy = rdy_cnt;
    for (int b = 0; b < 4; b++) wr_beat(beat(0, b));
    step();
    chk("load0_we_count", 64'(we_cnt - snap_we), 64'(31));
    chk("load0_ready_count", 64'(rdy_cnt - snap_rdy), 64'(4));
    chk("load0_contents", 64'(mem_bad(0, 0, 30, '0, 1'b0)), 64'(0));
    chk("load0_no_pad_write", 64'(mem[0][31]), 64'(8'hEE));

    // Replicas 1..31, then one more beat wraps onto replica 0
    for (int r = 1; r < 32; r++)
      for (int b = 0; b < 4; b++) wr_beat(beat(r, b));
    bad = 0;
    for (int r = 1; r < 32; r++) begin
      bad += mem_bad(r, 0, 30, '0, 1'b0);
      if (mem[r][31] !== 8'hEE) bad++;
    end
    chk("load_all_contents", 64'(bad), 64'(0));
    wr_beat(WRAP_BEAT);
    chk("wrap_rep0", 64'(mem_bad(0, 0, 7, WRAP_BEAT, 1'b1)), 64'(0));
    chk("wrap_rep1_untouched", 64'(mem_bad(1, 0, 7, '0, 1'b0)), 64'(0));

    // Pointer clear, then read back replica 0
    ptr_clear = 1'b1;
    step();
    ptr_clear = 1'b0;
    chk("clr_busy", 64'(io_busy), 64'(0));
    chk("clr_out_data", ordering_out_data, 64'(0));
    snap_re = re_cnt;
    rd_beat(WRAP_BEAT);
    rd_beat(beat(0, 1));
    rd_beat(beat(0, 2));
    rd_beat(beat(0, 3));
    chk("read_re_count", 64'(re_cnt - snap_re), 64'(31));

    // Write and read together: write path wins, lands on replica 1
    snap_re = re_cnt;
    snap_we = we_cnt;
    ordering_wdata = BOTH_BEAT;
    ordering_write = 1'b1;
    ordering_read  = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (ordering_ready !== 1'b1 && n < 20);
    ordering_write = 1'b0;
    ordering_read  = 1'b0;
    chk("both_ready", 64'(ordering_ready), 64'(1));
    chk("both_no_valid", 64'(ordering_out_valid), 64'(0));
    wait_idle("both_idle");
    step();
    chk("both_no_re", 64'(re_cnt - snap_re), 64'(0));
    chk("both_we_count", 64'(we_cnt - snap_we), 64'(8));
    chk("both_rep1", 64'(mem_bad(1, 0, 7, BOTH_BEAT, 1'b1)), 64'(0));

    // Reset in the middle of a serialised write
    ordering_wdata = RST_BEAT;
    ordering_write = 1'b1;
    step();
    chk("mid_ready", 64'(ordering_ready), 64'(1));
    ordering_write = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_busy", 64'(io_busy), 64'(0));
    chk("mid_we", 64'(ram_we), 64'(0));
    snap_we = we_cnt;
    step();
    step();
    step();
    chk("mid_no_more_we", 64'(we_cnt - snap_we), 64'(0));
    wr_beat(Y_BEAT);
    chk("after_rst_rep0", 64'(mem_bad(0, 0, 7, Y_BEAT, 1'b1)), 64'(0));

`ifdef ORDERING_CHECK_EN
    chk("err_clean", 64'(ordering_err), 64'(0));
    wr_beat(64'h01_1F_02_03_04_05_06_07);
    chk("err_set", 64'(ordering_err), 64'(1));
    wr_beat(beat(0, 2));
    chk("err_sticky", 64'(ordering_err), 64'(1));
    ptr_clear = 1'b1;
    step();
    ptr_clear = 1'b0;
    chk("err_cleared", 64'(ordering_err), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
